// File: rtl/tile_map_scroller_pkg.sv
// tile_map_scroller_pkg: shared tile-map defaults, direction bit indices and scroll wrap helper
package tile_map_scroller_pkg;
  localparam int TILE_LOG2_DEF = 4;
  localparam int MAP_COLS_DEF  = 40;
  localparam int MAP_ROWS_DEF  = 30;
  localparam int TILE_BITS_DEF = 4;
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;
  // Move a scroll offset by one step, wrapping into [0, size-1]
  function automatic logic [15:0] scroll_move(input logic [15:0] s, input int step, input int size,
                                              input logic inc, input logic dec);
    int v;
    v = int'(s);
    return inc ? 16'((v + step >= size) ? v + step - size : v + step) :
           dec ? 16'((v < step) ? v + size - step : v - step) : s;
  endfunction
endpackage

// File: rtl/tile_map_scroller_button_sync.sv
// button_sync: parametrised-width two-flop synchroniser with async active-high reset
module button_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_d, meta_q, sync_d, sync_q;
  // Next-state of both synchroniser stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end
  // Two back-to-back flops to settle metastability
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  assign q = sync_q;
endmodule

// File: rtl/tile_map_scroller.sv
// tile_map_scroller: per-pixel tile lookup over a wrapping map with button-driven per-frame scroll
module tile_map_scroller
  import tile_map_scroller_pkg::*;
#(
  parameter int H_START   = 145,
  parameter int V_START   = 32,
  parameter int TILE_LOG2 = TILE_LOG2_DEF,
  parameter int MAP_COLS  = MAP_COLS_DEF,
  parameter int MAP_ROWS  = MAP_ROWS_DEF,
  parameter int TILE_BITS = TILE_BITS_DEF,
  parameter int ADDR_W    = 13,
  parameter int STEP      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  input  logic                 bright,
  input  logic                 upb,
  input  logic                 downb,
  input  logic                 leftb,
  input  logic                 rightb,
  output logic [ADDR_W-1:0]    map_addr,
  input  logic [TILE_BITS-1:0] map_data,
  output logic [TILE_BITS-1:0] tselect,
  output logic [TILE_LOG2-1:0] tile_px,
  output logic [TILE_LOG2-1:0] tile_py,
  output logic                 tile_valid,
  output logic [3:0]           direction,
  output logic [15:0]          scroll_x,
  output logic [15:0]          scroll_y
);
  localparam int MW = MAP_COLS << TILE_LOG2;
  localparam int MH = MAP_ROWS << TILE_LOG2;
  logic [3:0] btn, mv;
  logic at_zero, armed_d, armed_q, strobe_d, strobe_q;
  logic [3:0] dir_d, dir_q;
  logic [15:0] sx_d, sx_q, sy_d, sy_q;
  logic [16:0] xr, yr, xw, yw;
  logic [ADDR_W-1:0] map_addr_d, map_addr_q;
  logic [TILE_LOG2-1:0] px1_d, px1_q, py1_d, py1_q, px2_q, py2_q, tile_px_q, tile_py_q;
  logic v1_d, v1_q, v2_q, tile_valid_q;
  logic [TILE_BITS-1:0] tselect_d, tselect_q;
  button_sync #(.W(4)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  ({rightb, leftb, downb, upb}),
    .q  (btn)
  );
  // Frame strobe, scroll steering and pixel-to-map-address arithmetic
  always_comb begin
    at_zero = (hcount == '0) && (vcount == '0);
    armed_d = !at_zero;
    strobe_d = at_zero && armed_q;
    mv = '0;
    mv[DIR_UP] = btn[DIR_UP] & ~btn[DIR_DOWN];
    mv[DIR_DOWN] = btn[DIR_DOWN] & ~btn[DIR_UP];
    mv[DIR_LEFT] = btn[DIR_LEFT] & ~btn[DIR_RIGHT];
    mv[DIR_RIGHT] = btn[DIR_RIGHT] & ~btn[DIR_LEFT];
    dir_d = strobe_q ? mv : dir_q;
    sx_d = strobe_q ? scroll_move(sx_q, STEP, MW, mv[DIR_RIGHT], mv[DIR_LEFT]) : sx_q;
    sy_d = strobe_q ? scroll_move(sy_q, STEP, MH, mv[DIR_DOWN], mv[DIR_UP]) : sy_q;
    xr = {7'd0, hcount} - 17'(H_START) + {1'b0, sx_q};
    yr = {7'd0, vcount} - 17'(V_START) + {1'b0, sy_q};
    xw = (xr >= 17'(MW)) ? xr - 17'(MW) : xr;
    yw = (yr >= 17'(MH)) ? yr - 17'(MH) : yr;
    map_addr_d = bright ? ADDR_W'(32'(yw >> TILE_LOG2) * 32'(MAP_COLS) + 32'(xw >> TILE_LOG2)) : '0;
    px1_d = bright ? xw[TILE_LOG2-1:0] : '0;
    py1_d = bright ? yw[TILE_LOG2-1:0] : '0;
    v1_d = bright;
    tselect_d = v2_q ? map_data : '0;
  end
  // Frame-strobe edge detector and per-frame scroll/direction state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      armed_q <= 1'b0;
      strobe_q <= 1'b0;
      dir_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      armed_q <= armed_d;
      strobe_q <= strobe_d;
      dir_q <= dir_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  // Three-stage pixel pipeline; stage 2 waits out the map ROM read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      map_addr_q <= '0;
      px1_q <= '0;
      py1_q <= '0;
      v1_q <= 1'b0;
      px2_q <= '0;
      py2_q <= '0;
      v2_q <= 1'b0;
      tselect_q <= '0;
      tile_px_q <= '0;
      tile_py_q <= '0;
      tile_valid_q <= 1'b0;
    end else begin
      map_addr_q <= map_addr_d;
      px1_q <= px1_d;
      py1_q <= py1_d;
      v1_q <= v1_d;
      px2_q <= px1_q;
      py2_q <= py1_q;
      v2_q <= v1_q;
      tselect_q <= tselect_d;
      tile_px_q <= px2_q;
      tile_py_q <= py2_q;
      tile_valid_q <= v2_q;
    end
  assign map_addr = map_addr_q;
  assign tselect = tselect_q;
  assign tile_px = tile_px_q;
  assign tile_py = tile_py_q;
  assign tile_valid = tile_valid_q;
  assign direction = dir_q;
  assign scroll_x = sx_q;
  assign scroll_y = sy_q;
endmodule

// File: doc/tile_map_scroller.md
# tile_map_scroller

Parametrised successor to the fixed 40×30 tile-map lookup. Takes the VGA timing counters and four push-buttons and produces, per active pixel, the map-ROM address, the returned tile select and the in-tile pixel offsets. A per-frame scroll offset is steered by the buttons, so the visible window pans across a wrapping tile map. Sits between the VGA timing generator and the tile pixel ROM stage.

## Interface
- H_START, 145: hcount value of first active pixel
- V_START, 32: vcount value of first active line
- TILE_LOG2, 4: log2 of tile edge in pixels
- MAP_COLS, 40: map width in tiles
- MAP_ROWS, 30: map height in tiles
- TILE_BITS, 4: width of tile select
- ADDR_W, 13: map-ROM address width; must satisfy 2^ADDR_W ≥ MAP_COLS·MAP_ROWS
- STEP, 2: scroll step in pixels per frame; 1 ≤ STEP < map size in pixels on each axis
- clk  in  1  system/pixel clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- hcount  in  10  horizontal counter from VGA timing
- vcount  in  10  vertical counter from VGA timing
- bright  in  1  active-video flag
- upb, downb, leftb, rightb  in  1 each  raw asynchronous buttons, active-high
- map_addr  out  ADDR_W  address to synchronous map ROM (1-cycle read latency)
- map_data  in  TILE_BITS  tile code returned by map ROM
- tselect  out  TILE_BITS  registered tile select
- tile_px, tile_py  out  TILE_LOG2 each  pixel offset inside tile, aligned with tselect
- tile_valid  out  1  tselect/offsets correspond to an active pixel
- direction  out  4  moves applied at last frame strobe: [0] up, [1] down, [2] left, [3] right
- scroll_x, scroll_y  out  16 each  current scroll offsets in pixels

## Operation
- Map size in pixels: MW = MAP_COLS<<TILE_LOG2, MH = MAP_ROWS<<TILE_LOG2.
- Buttons pass through a 2-FF synchroniser; only synchronised values are used.
- Frame strobe: registered flag, high one cycle on the first clk where (vcount,hcount)==(0,0) after any cycle where it was not; a held counter produces exactly one strobe.
- On frame strobe: up XOR down moves scroll_y; left XOR right moves scroll_x; both pressed on one axis → no move on that axis. Axes independent (diagonal allowed).
- Increment: s+STEP; if ≥ size, subtract size. Decrement: if s < STEP, s+size−STEP, else s−STEP. Scroll always within [0, size−1].
- direction loads the applied moves at each strobe and holds until the next strobe.
- Per pixel with bright=1: x = hcount−H_START+scroll_x, y = vcount−V_START+scroll_y, each wrapped by one conditional subtraction of MW/MH. col = x>>TILE_LOG2, row = y>>TILE_LOG2, map_addr = row·MAP_COLS+col.
- bright=0: map_addr=0, and tile_valid=0, tselect=0, tile_px=tile_py=0 at output stage.
- Scroll changes take effect for pixels sampled on the cycle after the strobe; no mid-frame change since strobe is at frame start.

## Timing
- Stage 1 (edge after inputs sampled): map_addr, offsets, valid registered.
- Stage 2: ROM presents map_data.
- Stage 3: tselect, tile_px, tile_py, tile_valid registered. Total latency hcount/vcount/bright → tselect = 3 clk.
- Button → scroll: 2 clk synchroniser + wait for next strobe.
- Reset (any time, including mid-line): all outputs, scroll, direction, pipeline and synchroniser regs 0 immediately; first strobe after release requires the (0,0) condition to appear fresh.

## Structure
- Shared package: TILE_LOG2, MAP_COLS, MAP_ROWS, TILE_BITS defaults and the direction bit-index constants (DIR_UP..DIR_RIGHT), reused by the sprite/player logic.
- One sub-module: button_sync (parametrised-width 2-FF synchroniser, async active-high reset).
- Map ROM stays outside the block.

## Test plan
- Reset, no buttons, bright=1, hcount=145, vcount=32 → 3 clk later map_addr(at stage1)=0, tselect=map_data of addr 0, tile_px=tile_py=0, tile_valid=1.
- Defaults, hcount=145+17, vcount=32+33, scroll 0 → map_addr=2·40+1=81, tile_px=1, tile_py=1.
- rightb held for 3 frame strobes, STEP=2 → scroll_x=6, direction=4'b1000; release → next strobe direction=0, scroll_x stays 6.
- scroll_x=0, leftb one strobe → scroll_x=638; then pixel hcount=145+5 → x=3, col 0, map_addr column 0.
- upb+downb+leftb together for one strobe → scroll_y unchanged, scroll_x decremented, direction=4'b0100.
- Counter held at (0,0) for 5 clk with rightb → scroll_x advances once; assert rst mid-line → all outputs 0 asynchronously.
